// File: rtl/fetch_unit.sv
// Instruction fetch responder: one word read per PC value over a valid/ready port,
// holding the result for decode. Optional WAIT/DRAIN timeout under `FETCH_TIMEOUT_EN`.
module fetch_unit #(
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR      = 32'h0000_0013,
    parameter int                    TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] pc_addr,
    input  logic                  flush,
    input  logic                  stall_in,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] instr,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic                  instr_valid,
    output logic                  fetch_fault,
    output logic                  mem_req_valid,
    output logic [DATA_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_ready,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] mem_rsp_data,
    input  logic                  mem_rsp_err
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_HOLD} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  fault_q, fault_d;
    logic                  valid_q;
    logic                  aligned;
    logic                  timeout;

    assign aligned = (pc_addr[1:0] == 2'b00);

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy;

    // Counter runs through WAIT and any following DRAIN; >= catches a flush that
    // moved WAIT to DRAIN right at the limit.
    assign busy    = (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign cnt_d   = busy ? cnt_q + 1'b1 : '0;
    assign timeout = busy && (cnt_q >= CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (flush) begin
                    if (aligned && mem_req_ready) state_d = S_DRAIN;
                end else if (!aligned) begin
                    state_d = S_HOLD;
                    instr_d = NOP_INSTR;
                    fault_d = 1'b1;
                    pc_d    = pc_addr;
                end else if (mem_req_ready) begin
                    state_d = S_WAIT;
                    pc_d    = pc_addr;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_d = mem_rsp_valid ? S_REQ : S_DRAIN;
                end else if (mem_rsp_valid) begin
                    state_d = S_HOLD;
                    instr_d = mem_rsp_err ? NOP_INSTR : mem_rsp_data;
                    fault_d = mem_rsp_err;
                end else if (timeout) begin
                    state_d = S_HOLD;
                    instr_d = NOP_INSTR;
                    fault_d = 1'b1;
                end
            end
            S_HOLD: if (flush || !stall_in) state_d = S_REQ;
            // A flush here changes nothing: the pending response is dropped either way.
            S_DRAIN: if (mem_rsp_valid || timeout) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            fault_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            valid_q <= (state_d == S_HOLD);
        end
    end

    assign stall         = !(((state_q == S_HOLD) && !stall_in) || flush);
    assign instr         = instr_q;
    assign instr_pc      = pc_q;
    assign instr_valid   = valid_q;
    assign fetch_fault   = fault_q;
    assign mem_req_valid = (state_q == S_REQ) && aligned;
    assign mem_req_addr  = pc_addr;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a PC model, a latency-programmable memory
// responder, directed scenarios pushing expected deliveries, and a monitor.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_addr;
    logic        flush, stall_in, stall;
    logic [31:0] instr, instr_pc;
    logic        instr_valid, fetch_fault;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid, mem_rsp_err;
    logic [31:0] mem_rsp_data;
    logic [31:0] flush_tgt;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   pops  = 0;

    fetch_unit #(.DATA_WIDTH(32), .NOP_INSTR(NOP), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .pc_addr(pc_addr), .flush(flush), .stall_in(stall_in),
        .stall(stall), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .fetch_fault(fetch_fault), .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        case (a)
            32'h00: return 32'h0050_0093;
            32'h04: return 32'h0010_0113;
            32'h20: return 32'hDEAD_BEEF;
            32'h40: return 32'h1234_5678;
            default: return 32'h0000_0033;
        endcase
    endfunction

    function automatic int mem_lat(input logic [31:0] a);
        case (a)
            32'h20: return 2;
            32'h80: return 6;
            default: return 1;
        endcase
    endfunction

    // Memory: a handshake seen in a cycle is answered mem_lat cycles later for one cycle.
    initial begin
        logic [31:0] a;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        mem_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && mem_req_valid && mem_req_ready) begin
                a = mem_req_addr;
                repeat (mem_lat(a)) @(posedge clk);
                #1;
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = mem_data(a);
                mem_rsp_err   = (a == 32'h44);
                @(posedge clk);
                #1;
                mem_rsp_valid = 1'b0;
                mem_rsp_data  = '0;
                mem_rsp_err   = 1'b0;
            end
        end
    end

    // PC model: advances by 4 or to the redirect target whenever stall is low.
    initial begin
        logic        adv;
        logic [31:0] nxt;
        pc_addr = '0;
        forever begin
            @(negedge clk);
            adv = (rst === 1'b1) && !stall;
            nxt = flush ? flush_tgt : pc_addr + 32'd4;
            @(posedge clk);
            #1;
            if (rst !== 1'b1) pc_addr = '0;
            else if (adv)     pc_addr = nxt;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1) begin
            check("stall_eq", {31'b0, stall}, {31'b0, !((instr_valid && !stall_in) || flush)});
            if (pc_addr[1:0] != 2'b00) check("no_req_misaligned", {31'b0, mem_req_valid}, 32'd0);
            if (instr_valid && !stall_in && !flush) begin
                pops++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_delivery: got instr %h pc %h, none expected", instr, instr_pc);
                end else begin
                    e = sb.pop_front();
                    check("deliv_instr", instr, e.ins);
                    check("deliv_pc", instr_pc, e.pc);
                    check("deliv_fault", {31'b0, fetch_fault}, {31'b0, e.fault});
                end
            end
        end
    end

    task automatic push(input logic [31:0] ins, input logic [31:0] pc, input logic fault);
        exp_t e;
        e.ins = ins; e.pc = pc; e.fault = fault;
        sb.push_back(e);
    endtask

    task automatic wait_hold(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!instr_valid && n < 40);
        if (!instr_valid) begin
            tests++;
            fails++;
            $display("FAIL wait_hold: got no instr_valid within %0d cycles, required delivery", n);
        end
    endtask

    task automatic release_one();
        int p;
        p = pops;
        @(posedge clk); #1 stall_in = 1'b0;
        @(negedge clk); #1;
        check("accept_on_release", pops, p + 1);
        @(posedge clk); #1 stall_in = 1'b1;
    endtask

    task automatic redirect(input logic [31:0] tgt);
        @(posedge clk); #1 flush = 1'b1; flush_tgt = tgt;
        @(posedge clk); #1 flush = 1'b0;
    endtask

    task automatic check_reset_vals();
        check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_fault", {31'b0, fetch_fault}, 32'd0);
        check("rst_instr", instr, NOP);
        check("rst_instr_pc", instr_pc, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of run, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0; stall_in = 1'b0; flush = 1'b0; flush_tgt = '0; mem_req_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals();

        // Single fetch straight out of reset
        push(32'h0050_0093, 32'h0, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        wait_hold(n);
        check("first_latency", n, 4);
        @(posedge clk); #1 stall_in = 1'b1;
        @(negedge clk);
        check("stall_one_cycle", {31'b0, stall}, 32'd1);

        // Backpressure on the fetch at 4
        push(32'h0010_0113, 32'h4, 1'b0);
        wait_hold(n);
        for (int i = 0; i < 5; i++) begin
            check("bp_instr", instr, 32'h0010_0113);
            check("bp_pc", instr_pc, 32'h4);
            check("bp_valid", {31'b0, instr_valid}, 32'd1);
            check("bp_stall", {31'b0, stall}, 32'd1);
            check("bp_no_req", {31'b0, mem_req_valid}, 32'd0);
            if (i < 4) @(negedge clk);
        end
        release_one();
        wait_hold(n);                     // parks on the fetch at 8

        // Misaligned redirect
        redirect(32'h6);
        push(NOP, 32'h6, 1'b1);
        wait_hold(n);
        check("mis_latency", n, 2);
        check("mis_instr", instr, NOP);
        check("mis_fault", {31'b0, fetch_fault}, 32'd1);
        check("mis_pc", instr_pc, 32'h6);
        release_one();
        wait_hold(n);                     // parks on the fault at 10

        // Flush during WAIT; the slow response for 0x20 lands in DRAIN
        redirect(32'h20);
        @(posedge clk); #1 flush = 1'b1; flush_tgt = 32'h40;
        @(posedge clk); #1 flush = 1'b0;
        push(32'h1234_5678, 32'h40, 1'b0);
        wait_hold(n);
        release_one();

        // Bus error at 0x44
        push(NOP, 32'h44, 1'b1);
        wait_hold(n);
        release_one();
        wait_hold(n);                     // parks on the fetch at 0x48

`ifdef FETCH_TIMEOUT_EN
        // No response for 4 WAIT cycles; the response arriving later is ignored
        redirect(32'h80);
        push(NOP, 32'h80, 1'b1);
        wait_hold(n);
        check("timeout_latency", n, 6);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("late_rsp_instr", instr, NOP);
            check("late_rsp_fault", {31'b0, fetch_fault}, 32'd1);
        end
        release_one();
        wait_hold(n);
`endif

        // Reset mid-operation
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_vals();
        check("sb_empty", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
